// File: rtl/result_drain.sv
// Drains per-PE match vectors into a stream of global weight indices, one per accepted transfer.
// Optional accepted-match counter is compiled in when RESULT_DRAIN_COUNT_EN is defined.
module result_drain #(
    parameter int groups               = 4,
    parameter int num                  = 4,
    parameter int max_number_of_weight = num * groups,
    parameter int weight_num           = 23331,
    parameter int IDW                  = 15,
    parameter int DEPTH                = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            result_valid,
    input  logic [max_number_of_weight-1:0] result,
    input  logic [IDW-1:0]                  batch_base,
    input  logic                            string_finish,
    output logic                            match_valid,
    input  logic                            match_ready,
    output logic [IDW-1:0]                  match_id,
    output logic                            busy,
    output logic                            done,
    output logic                            overflow,
    output logic [31:0]                     match_count
);
    localparam int MAXW = max_number_of_weight;
    localparam int AW   = $clog2(DEPTH);
    localparam int IW   = (MAXW > 1) ? $clog2(MAXW) : 1;

    if (weight_num > (1 << IDW)) begin : g_idw_check
        $error("IDW is too narrow to index weight_num weights");
    end

    typedef enum logic {ST_IDLE, ST_SCAN} state_t;

    state_t          r_state;
    logic [MAXW-1:0] r_work;
    logic [IDW-1:0]  r_wbase;
    logic [AW:0]     r_wr_ptr;
    logic [AW:0]     r_rd_ptr;
    logic            r_overflow;
    logic            r_finish_pending;
    logic            r_done;
    logic [MAXW-1:0] r_mem_res  [DEPTH];
    logic [IDW-1:0]  r_mem_base [DEPTH];

    logic [AW:0]     w_count;
    logic            w_empty;
    logic            w_full;
    logic            w_nz_in;
    logic            w_accept;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic            w_done_cond;
    logic [MAXW-1:0] w_work_clr;
    logic [IW-1:0]   w_low_idx;
    logic [MAXW-1:0] w_head_res;
    logic [IDW-1:0]  w_head_base;

    assign w_count     = r_wr_ptr - r_rd_ptr;
    assign w_empty     = (w_count == '0);
    assign w_full      = (w_count == (AW+1)'(DEPTH));
    assign w_nz_in     = result_valid && (result != '0);
    assign w_accept    = (r_state == ST_SCAN) && match_ready;
    assign w_work_clr  = r_work & (r_work - MAXW'(1));
    assign w_head_res  = r_mem_res[r_rd_ptr[AW-1:0]];
    assign w_head_base = r_mem_base[r_rd_ptr[AW-1:0]];

    // Pop either to start a scan, or in the same cycle the last bit of the working vector goes out.
    assign w_pop  = !w_empty && ((r_state == ST_IDLE) || (w_accept && (w_work_clr == '0)));
    assign w_push = w_nz_in && (!w_full || w_pop);
    assign w_drop = w_nz_in && w_full && !w_pop;
    assign w_done_cond = r_finish_pending && w_empty && (r_state == ST_IDLE) && !w_nz_in;

    always_comb begin
        w_low_idx = '0;
        for (int i = MAXW - 1; i >= 0; i--) begin
            if (r_work[i]) w_low_idx = IW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_res[r_wr_ptr[AW-1:0]]  <= result;
            r_mem_base[r_wr_ptr[AW-1:0]] <= batch_base;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_work           <= '0;
            r_wbase          <= '0;
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_overflow       <= 1'b0;
            r_finish_pending <= 1'b0;
            r_done           <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            if (w_drop) r_overflow <= 1'b1;
            r_done           <= w_done_cond;
            r_finish_pending <= string_finish || (r_finish_pending && !w_done_cond);
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_work  <= w_head_res;
                        r_wbase <= w_head_base;
                        r_state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (w_accept) begin
                        if (w_work_clr != '0) begin
                            r_work <= w_work_clr;
                        end else if (w_pop) begin
                            r_work  <= w_head_res;
                            r_wbase <= w_head_base;
                        end else begin
                            r_work  <= '0;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign match_valid = (r_state == ST_SCAN);
    assign match_id    = (r_state == ST_SCAN) ? (r_wbase + IDW'(w_low_idx)) : '0;
    assign busy        = !w_empty || (r_state == ST_SCAN);
    assign done        = r_done;
    assign overflow    = r_overflow;

`ifdef RESULT_DRAIN_COUNT_EN
    logic [31:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || r_done) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign match_count = r_count;
`else
    assign match_count = '0;
`endif
endmodule

// File: tb/tb_result_drain.sv
// Scoreboard bench for result_drain: stimulus pushes expected indices, a negedge monitor pops and compares.
module tb_result_drain;
    localparam int MAXW  = 16;
    localparam int IDW   = 15;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            result_valid;
    logic [MAXW-1:0] result;
    logic [IDW-1:0]  batch_base;
    logic            string_finish;
    logic            match_valid;
    logic            match_ready;
    logic [IDW-1:0]  match_id;
    logic            busy;
    logic            done;
    logic            overflow;
    logic [31:0]     match_count;

    result_drain #(
        .groups(4), .num(4), .max_number_of_weight(MAXW),
        .weight_num(23331), .IDW(IDW), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .result_valid(result_valid), .result(result),
        .batch_base(batch_base), .string_finish(string_finish),
        .match_valid(match_valid), .match_ready(match_ready), .match_id(match_id),
        .busy(busy), .done(done), .overflow(overflow), .match_count(match_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [IDW-1:0] exp_q[$];
    bit             last_q[$];
    int pushed_vecs  = 0;
    int drained_vecs = 0;
    int done_cnt     = 0;
    int done_cyc     = -1;
    int cyc          = 0;
    int last_xfer    = -10;
    int prev_xfer    = -10;
    logic [31:0]    m_cnt = '0;
    bit             stall_prev = 1'b0;
    logic [IDW-1:0] held_id = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: each set bit i of a kept vector yields (base + i) mod 2^IDW, ascending.
    task automatic push_vec(input logic [MAXW-1:0] v, input logic [IDW-1:0] b,
                            input bit fin, input bit kept);
        int hi;
        logic [IDW-1:0] id;
        result_valid  = 1'b1;
        result        = v;
        batch_base    = b;
        string_finish = fin;
        if (v != '0 && kept) begin
            hi = 0;
            for (int i = 0; i < MAXW; i++) if (v[i]) hi = i;
            for (int i = 0; i < MAXW; i++) begin
                if (v[i]) begin
                    id = b + IDW'(i);
                    exp_q.push_back(id);
                    last_q.push_back(i == hi);
                end
            end
            pushed_vecs++;
        end
        step();
        result_valid  = 1'b0;
        result        = '0;
        string_finish = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            #2;
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: drain timed out, %0d ids outstanding, expected 0", name, exp_q.size());
        end
    endtask

    task automatic rand_vec(output logic [MAXW-1:0] v);
        v = '0;
        repeat ($urandom_range(1, 4)) v[$urandom_range(0, MAXW-1)] = 1'b1;
    endtask

    // Monitor: compares every accepted transfer against the scoreboard and checks handshake rules.
    always @(negedge clk) begin
        cyc++;
`ifdef RESULT_DRAIN_COUNT_EN
        check("match_count", match_count, m_cnt);
`else
        check("match_count", match_count, 0);
`endif
        if (reset) begin
            stall_prev = 1'b0;
            m_cnt      = '0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", match_valid, 1);
                check("hold_id", match_id, held_id);
            end
            if (match_valid && match_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_id: got %0d expected no transfer", match_id);
                end else begin
                    check("match_id", match_id, exp_q.pop_front());
                    if (last_q.pop_front()) drained_vecs++;
                end
                prev_xfer = last_xfer;
                last_xfer = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_drained", exp_q.size(), 0);
                check("done_busy", busy, 0);
            end
            stall_prev = match_valid && !match_ready;
            held_id    = match_id;
            if (done) m_cnt = '0;
            else if (match_valid && match_ready) m_cnt = m_cnt + 32'd1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [MAXW-1:0] v;
        int d0;
        int dr0;
        reset         = 1'b1;
        result_valid  = 1'b0;
        result        = '0;
        batch_base    = '0;
        string_finish = 1'b0;
        match_ready   = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        @(negedge clk);
        check("rst_valid", match_valid, 0);
        check("rst_id", match_id, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_count", match_count, 0);

        // Single vector with two-cycle latency and back-to-back ids.
        step();
        match_ready = 1'b1;
        push_vec(16'h8005, 15'd100, 1'b0, 1'b1);
        @(negedge clk);
        check("lat_early", match_valid, 0);
        step();
        @(negedge clk);
        check("lat_valid", match_valid, 1);
        check("lat_first_id", match_id, 100);
        wait_drain("single");
        check("single_gap", last_xfer - prev_xfer, 1);
        @(negedge clk);
        check("single_busy", busy, 0);

        // Backpressure: id must hold while not ready.
        step();
        match_ready = 1'b0;
        push_vec(16'h8005, 15'd100, 1'b0, 1'b1);
        for (int n = 0; n < 20 && !match_valid; n++) step();
        repeat (3) step();
        @(negedge clk);
        check("bp_valid", match_valid, 1);
        check("bp_id", match_id, 100);
        step();
        match_ready = 1'b1;
        wait_drain("backpressure");

        // Back-to-back vectors drain without a bubble.
        step();
        push_vec(16'h0001, 15'd0, 1'b0, 1'b1);
        push_vec(16'h0002, 15'd16, 1'b0, 1'b1);
        wait_drain("b2b");
        check("b2b_gap", last_xfer - prev_xfer, 1);

        // Overflow: DEPTH+2 vectors with no drain; the last is dropped.
        step();
        match_ready = 1'b0;
        dr0 = drained_vecs;
        for (int k = 0; k < DEPTH + 2; k++) begin
            if (k == DEPTH + 1) check("ovf_before", overflow, 0);
            rand_vec(v);
            push_vec(v, IDW'(k * 1000 + 32700), 1'b0, k <= DEPTH);
        end
        @(negedge clk);
        check("ovf_set", overflow, 1);
        step();
        match_ready = 1'b1;
        wait_drain("overflow");
        repeat (2) step();
        check("ovf_drained", drained_vecs - dr0, DEPTH + 1);
        check("ovf_sticky", overflow, 1);
        check("ovf_idle", busy, 0);

        // Finish with a zero vector, then finish with a 2-bit vector pending.
        d0 = done_cnt;
        push_vec(16'h0000, 15'd0, 1'b1, 1'b0);
        repeat (6) step();
        check("done_zero", done_cnt, d0 + 1);
        push_vec(16'h0090, 15'd200, 1'b1, 1'b1);
        wait_drain("finish");
        repeat (6) step();
        check("done_pending", done_cnt, d0 + 2);
        total++;
        if (done_cyc - last_xfer < 1 || done_cyc - last_xfer > 2) begin
            bad++;
            $display("FAIL done_delay: got %0d cycles after last transfer expected 1..2", done_cyc - last_xfer);
        end

        // Reset mid-scan discards everything, including the sticky overflow.
        match_ready = 1'b0;
        push_vec(16'hFFFF, 15'd5000, 1'b0, 1'b1);
        for (int n = 0; n < 20 && !match_valid; n++) step();
        reset = 1'b1;
        exp_q.delete();
        last_q.delete();
        pushed_vecs = drained_vecs;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", match_valid, 0);
        check("mid_rst_id", match_id, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_overflow", overflow, 0);
        check("mid_rst_count", match_count, 0);

        // Randomized traffic kept below capacity so nothing is dropped.
        for (int n = 0; n < 400; n++) begin
            match_ready = ($urandom_range(0, 3) != 0);
            if ((pushed_vecs - drained_vecs) < DEPTH && $urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 5) == 0) v = '0;
                else rand_vec(v);
                push_vec(v, IDW'($urandom_range(0, 32767)), ($urandom_range(0, 7) == 0), 1'b1);
            end else begin
                step();
            end
        end
        match_ready = 1'b1;
        wait_drain("random");
        repeat (4) step();
        check("rand_overflow", overflow, 0);
        check("rand_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/result_drain.md
# result_drain

Output-side counterpart of `weight_cut` in the string-matching array. `weight_cut` pushes weight batches into the controller and PE groups; `result_drain` takes the per-PE match vectors coming back through the routers and turns them into a stream of global weight indices. It buffers whole result vectors in a small FIFO and serializes the set bits one index per accepted transfer. It also signals when all results for a finished string have been drained.

## Interface
Parameters:
- `groups`, 4, PE groups (one router each)
- `num`, 4, PEs per group
- `max_number_of_weight`, `num*groups`, result vector width (MAXW)
- `weight_num`, 23331, total weights in the dictionary
- `IDW`, 15, width of a global weight index (ceil log2 `weight_num`)
- `DEPTH`, 4, result-vector FIFO depth (power of two, ≥2)

Ports:
- `clk`, in, 1, sole clock
- `reset`, in, 1, synchronous, active-high
- `result_valid`, in, 1, `result` and `batch_base` are valid this cycle
- `result`, in, MAXW, match bits; bit i = PE i matched
- `batch_base`, in, IDW, global index of the weight loaded in PE 0 for this batch
- `string_finish`, in, 1, last batch of the current string has been issued
- `match_valid`, out, 1, `match_id` is valid
- `match_ready`, in, 1, downstream accepts `match_id`
- `match_id`, out, IDW, global index of a matched weight
- `busy`, out, 1, FIFO non-empty or a vector is being scanned
- `done`, out, 1, one-cycle pulse when all results of a finished string have been drained
- `overflow`, out, 1, sticky flag: a result vector was dropped
- `match_count`, out, 32, number of accepted matches (see Configuration)

## Operation
- **Enqueue.**
  - On `result_valid` with `result != 0`, write {`result`, `batch_base`} into the FIFO.
  - All-zero vectors are never enqueued.
- **States:** IDLE (no working vector) and SCAN (a working vector `work` with base `wbase` is held).
- **IDLE.**
  - If the FIFO is non-empty: pop the head into `work`/`wbase` and go to SCAN.
  - Otherwise stay in IDLE.
- **SCAN.**
  - `match_valid` = 1.
  - `match_id` = (`wbase` + index of the lowest set bit of `work`) mod 2^IDW.
  - On `match_valid && match_ready`: clear that bit.
  - If the cleared bit was the last set bit:
    - FIFO non-empty: pop the next entry in the same cycle and stay in SCAN (no bubble).
    - FIFO empty: go to IDLE.
- **Full FIFO.**
  - Pop and push in the same cycle are both permitted, including when the FIFO is full.
  - A nonzero vector arriving while full with no pop that cycle is dropped and sets `overflow`.
  - `overflow` stays set until `reset`.
- **Finish.**
  - `string_finish` sets `finish_pending`.
  - `done` pulses for 1 cycle and clears `finish_pending` once all of these hold: `finish_pending`, FIFO empty, state IDLE, and no nonzero `result_valid` in that cycle.
  - If `string_finish` and `result_valid` arrive together, the vector is enqueued first and `done` waits until it has drained.
- **Reset** (including mid-scan): FIFO emptied, state IDLE, `work` = 0, `finish_pending` = 0. Any in-flight vectors are discarded without flagging `overflow`.

## Timing
- Reset values: `match_valid` 0, `match_id` 0, `busy` 0, `done` 0, `overflow` 0, `match_count` 0.
- Latency:
  - Vector sampled at edge t is in the FIFO during cycle t+1.
  - It is popped at edge t+1.
  - `match_valid` is high in cycle t+2.
- Throughput: 1 index per cycle while `match_ready` = 1. A vector with k set bits occupies SCAN for exactly k accepted transfers.
- Handshake stability:
  - While `match_valid && !match_ready`, `match_id` is held stable.
  - `match_valid` never deasserts without a transfer, except on `reset`.
- `done` is registered: it rises the cycle after its condition is met.
- `busy` is combinational: (FIFO count ≠ 0) or (state = SCAN).

## Configuration
- Macro: `RESULT_DRAIN_COUNT_EN`.
- Defined:
  - `match_count` increments by 1 on every `match_valid && match_ready`.
  - It wraps at 2^32 and clears on `reset` and on `done`. The `done` cycle shows the final count; the next cycle shows 0.
- Undefined: no counter logic is compiled; `match_count` is tied to 0.

## Test plan
- **Single vector.** `result` = 16'h8005, `batch_base` = 100, `match_ready` held 1.
  - `match_id` = 100, 102, 115 on three consecutive cycles starting 2 cycles after input; then `busy` = 0.
- **Backpressure.** Same vector with `match_ready` low for 3 cycles.
  - `match_id` holds at 100 with `match_valid` = 1; no index is lost or duplicated.
- **Back-to-back.** Vectors {16'h0001, base 0} and {16'h0002, base 16} on consecutive cycles.
  - IDs 0 then 17 on consecutive cycles, with no bubble.
- **Overflow.** `match_ready` = 0, DEPTH+2 nonzero vectors pushed.
  - `overflow` = 1 after the first vector that arrives with the FIFO full and no pop that cycle.
  - After releasing `match_ready`, exactly the first DEPTH+1 vectors drain (one in `work`, DEPTH in the FIFO).
- **Finish and zero vectors.** All-zero vector plus `string_finish` in the same cycle.
  - `done` pulses in the next cycle.
  - With a pending vector of 2 bits, `done` pulses one cycle after the last transfer.
- **Reset mid-scan.** `reset` asserted while in SCAN.
  - All outputs return to reset values next cycle.
  - With `RESULT_DRAIN_COUNT_EN` defined, `match_count` reads 0.
